// File: rtl/map_mem_arbiter_if.sv
// Bus bundle for map_mem_arbiter: CPU (prg) and PPU (chr) request channels plus the
// shared memory command/response port.
interface map_mem_arbiter_if #(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 prg_req;
  logic                 prg_we;
  logic [ADDR_BITS-1:0] prg_addr;
  logic [7:0]           prg_wdata;
  logic                 prg_ack;
  logic [7:0]           prg_rdata;

  logic                 chr_req;
  logic                 chr_we;
  logic [ADDR_BITS-1:0] chr_addr;
  logic [7:0]           chr_wdata;
  logic                 chr_ack;
  logic [7:0]           chr_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_ready;
  logic                 mem_done;
  logic [7:0]           mem_rdata;

  modport arb (
    input  prg_req, prg_we, prg_addr, prg_wdata,
    output prg_ack, prg_rdata,
    input  chr_req, chr_we, chr_addr, chr_wdata,
    output chr_ack, chr_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_done, mem_rdata
  );

  modport host (
    output prg_req, prg_we, prg_addr, prg_wdata,
    input  prg_ack, prg_rdata,
    output chr_req, chr_we, chr_addr, chr_wdata,
    input  chr_ack, chr_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_done, mem_rdata
  );
endinterface

// File: rtl/map_mem_arbiter.sv
// Two-channel (prg/chr) arbiter onto one byte-wide memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is fixed CHR priority.
module map_mem_arbiter #(
  parameter int unsigned ADDR_BITS = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  map_mem_arbiter_if.arb   bus,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic {CH_PRG, CH_CHR} chan_t;

  state_t               state, state_d;
  chan_t                grant, grant_d;
  logic                 mem_we_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [7:0]           mem_wdata_q;
  logic [7:0]           prg_rdata_q;
  logic [7:0]           chr_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
  chan_t                last_grant;
`endif

  always_comb begin
    state_d = state;
    grant_d = grant;
    case (state)
      IDLE: begin
        if (bus.prg_req || bus.chr_req) begin
          state_d = ISSUE;
          if (bus.prg_req && bus.chr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_d = (last_grant == CH_PRG) ? CH_CHR : CH_PRG;
`else
            grant_d = CH_CHR;
`endif
          end else begin
            grant_d = bus.prg_req ? CH_PRG : CH_CHR;
          end
        end
      end
      ISSUE:   if (bus.mem_ready) state_d = WAIT;
      WAIT:    if (bus.mem_done)  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= CH_CHR;
    end else begin
      state <= state_d;
      grant <= grant_d;
    end
  end

  // Command fields latch only on the IDLE->ISSUE edge, so they stay frozen through backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      prg_rdata_q <= '0;
      chr_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= CH_CHR;
`endif
    end else begin
      if (state == IDLE && state_d == ISSUE) begin
        if (grant_d == CH_PRG) begin
          mem_we_q    <= bus.prg_we;
          mem_addr_q  <= bus.prg_addr;
          mem_wdata_q <= bus.prg_wdata;
        end else begin
          mem_we_q    <= bus.chr_we;
          mem_addr_q  <= bus.chr_addr;
          mem_wdata_q <= bus.chr_wdata;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_grant <= grant_d;
`endif
      end
      if (state == WAIT && bus.mem_done && !mem_we_q) begin
        if (grant == CH_PRG) prg_rdata_q <= bus.mem_rdata;
        else                 chr_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = (state == ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.prg_ack   = (state == ACK) && (grant == CH_PRG);
  assign bus.chr_ack   = (state == ACK) && (grant == CH_CHR);
  assign bus.prg_rdata = prg_rdata_q;
  assign bus.chr_rdata = chr_rdata_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Directed bench for map_mem_arbiter: reads, backpressured write, reset mid-transaction,
// arbitration under contention and spurious mem_done.
module tb_map_mem_arbiter;

  localparam int unsigned AB = 24;

  logic clk;
  logic reset_n;
  logic busy;
  int   total;
  int   passed;
  logic [7:0] exp_prg_rd;
  logic [7:0] exp_chr_rd;
  logic       exp_g_prg;

  map_mem_arbiter_if #(.ADDR_BITS(AB)) bus ();

  map_mem_arbiter #(.ADDR_BITS(AB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset_n = 1'b0;
    bus.prg_req = 0; bus.prg_we = 0; bus.prg_addr = '0; bus.prg_wdata = '0;
    bus.chr_req = 0; bus.chr_we = 0; bus.chr_addr = '0; bus.chr_wdata = '0;
    bus.mem_ready = 0; bus.mem_done = 0; bus.mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_prg_rdata", 32'(bus.prg_rdata), 0);
    chk("rst_chr_rdata", 32'(bus.chr_rdata), 0);
    chk("rst_acks", {30'b0, bus.prg_ack, bus.chr_ack}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single PRG read, minimum latency
    bus.prg_req = 1; bus.prg_we = 0; bus.prg_addr = 24'h001234; bus.mem_ready = 1;
    @(negedge clk);
    chk("t1_mem_req", 32'(bus.mem_req), 1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h001234);
    chk("t1_mem_we", 32'(bus.mem_we), 0);
    chk("t1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t1_wait_req", 32'(bus.mem_req), 0);
    chk("t1_wait_ack", 32'(bus.prg_ack), 0);
    bus.mem_done = 1; bus.mem_rdata = 8'hA5;
    @(negedge clk);
    bus.mem_done = 0;
    chk("t1_prg_ack", 32'(bus.prg_ack), 1);
    chk("t1_chr_ack", 32'(bus.chr_ack), 0);
    chk("t1_prg_rdata", 32'(bus.prg_rdata), 32'hA5);
    bus.prg_req = 0;
    @(negedge clk);
    chk("t1_ack_drop", 32'(bus.prg_ack), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_rdata_hold", 32'(bus.prg_rdata), 32'hA5);

    // CHR write with 4 cycles of backpressure
    bus.mem_ready = 0;
    bus.chr_req = 1; bus.chr_we = 1; bus.chr_addr = 24'h000010; bus.chr_wdata = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) bus.mem_ready = 1;
      chk($sformatf("t2_req_c%0d", i), 32'(bus.mem_req), 1);
      chk($sformatf("t2_cmd_c%0d", i), {bus.mem_we, bus.mem_wdata, bus.mem_addr[22:0]},
          {1'b1, 8'h3C, 23'h000010});
    end
    @(negedge clk);
    bus.mem_ready = 0;
    chk("t2_wait_req", 32'(bus.mem_req), 0);
    bus.mem_done = 1; bus.mem_rdata = 8'hFF;
    @(negedge clk);
    bus.mem_done = 0;
    chk("t2_chr_ack", 32'(bus.chr_ack), 1);
    chk("t2_prg_ack", 32'(bus.prg_ack), 0);
    chk("t2_chr_rdata", 32'(bus.chr_rdata), 0);
    bus.chr_req = 0; bus.chr_we = 0;
    @(negedge clk);
    chk("t2_ack_drop", 32'(bus.chr_ack), 0);

    // Reset asserted while waiting on memory; late mem_done must be ignored
    bus.mem_ready = 1;
    bus.prg_req = 1; bus.prg_addr = 24'h00BEEF;
    @(negedge clk);
    @(negedge clk);
    reset_n = 0; bus.prg_req = 0;
    #1;
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_req", 32'(bus.mem_req), 0);
    chk("t4_rst_rdata", 32'(bus.prg_rdata), 0);
    #2 reset_n = 1;
    @(negedge clk);
    bus.mem_done = 1; bus.mem_rdata = 8'hEE;
    @(negedge clk);
    bus.mem_done = 0;
    chk("t4_no_ack", {30'b0, bus.prg_ack, bus.chr_ack}, 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_mem_req", 32'(bus.mem_req), 0);
    chk("t4_rdata", 32'(bus.prg_rdata), 0);

    // Contention: both channels held requesting
    bus.prg_req = 1; bus.prg_addr = 24'h000100;
    bus.chr_req = 1; bus.chr_addr = 24'h000200;
    exp_prg_rd = 8'h00; exp_chr_rd = 8'h00;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g_prg = (t != 1);
`else
      exp_g_prg = (t == 3);
`endif
      @(negedge clk);
      chk($sformatf("t3_addr_%0d", t), 32'(bus.mem_addr), exp_g_prg ? 32'h100 : 32'h200);
      @(negedge clk);
      bus.mem_done = 1; bus.mem_rdata = 8'h10 + 8'(t);
      @(negedge clk);
      bus.mem_done = 0;
      if (exp_g_prg) exp_prg_rd = 8'h10 + 8'(t);
      else           exp_chr_rd = 8'h10 + 8'(t);
      chk($sformatf("t3_acks_%0d", t), {30'b0, bus.prg_ack, bus.chr_ack},
          exp_g_prg ? 32'd2 : 32'd1);
      chk($sformatf("t3_rd_%0d", t), {16'b0, bus.prg_rdata, bus.chr_rdata},
          {16'b0, exp_prg_rd, exp_chr_rd});
      if (t == 2) bus.chr_req = 0;
      if (t == 3) bus.prg_req = 0;
      @(negedge clk);
    end

    // Spurious mem_done in IDLE
    bus.mem_done = 1; bus.mem_rdata = 8'h77;
    @(negedge clk);
    bus.mem_done = 0;
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_acks", {30'b0, bus.prg_ack, bus.chr_ack}, 0);
    chk("t5_idle_rd", {16'b0, bus.prg_rdata, bus.chr_rdata}, {16'b0, exp_prg_rd, exp_chr_rd});

    // Spurious mem_done in ISSUE
    bus.mem_ready = 0; bus.prg_req = 1; bus.prg_we = 0; bus.prg_addr = 24'h0ABCDE;
    @(negedge clk);
    chk("t5_issue_req", 32'(bus.mem_req), 1);
    bus.mem_done = 1; bus.mem_rdata = 8'h66;
    @(negedge clk);
    bus.mem_done = 0;
    chk("t5_issue_hold", 32'(bus.mem_req), 1);
    chk("t5_issue_addr", 32'(bus.mem_addr), 32'h0ABCDE);
    chk("t5_issue_ack", 32'(bus.prg_ack), 0);
    chk("t5_issue_rd", 32'(bus.prg_rdata), 32'(exp_prg_rd));
    bus.mem_ready = 1;
    @(negedge clk);
    chk("t5_wait_req", 32'(bus.mem_req), 0);
    bus.mem_done = 1; bus.mem_rdata = 8'h5A;
    @(negedge clk);
    bus.mem_done = 0;
    chk("t5_ack", 32'(bus.prg_ack), 1);
    chk("t5_rdata", 32'(bus.prg_rdata), 32'h5A);
    bus.prg_req = 0;
    @(negedge clk);
    chk("t5_end_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
